// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scanner: active-low segment patterns
// ({g,f,e,d,c,b,a}), the overflow code/word and the blink phase type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Upstream marks an out-of-range digit with 4'hF; all four set means overflow.
  localparam logic [3:0]  OVF_CODE = 4'hF;
  localparam logic [15:0] OVF_WORD = 16'hFFFF;

  typedef enum logic {
    VISIBLE = 1'b0,
    DARK    = 1'b1
  } blink_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-segment decoder, active-low outputs.
// Codes 10..14 are invalid and render blank; the overflow code renders a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Map the digit code to its segment pattern, honouring the blank request.
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (code_i)
        4'd0:     seg_o = SEG_0;
        4'd1:     seg_o = SEG_1;
        4'd2:     seg_o = SEG_2;
        4'd3:     seg_o = SEG_3;
        4'd4:     seg_o = SEG_4;
        4'd5:     seg_o = SEG_5;
        4'd6:     seg_o = SEG_6;
        4'd7:     seg_o = SEG_7;
        4'd8:     seg_o = SEG_8;
        4'd9:     seg_o = SEG_9;
        OVF_CODE: seg_o = SEG_DASH;
        default:  seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode display scanner.
// A refresh counter divides Clk into digit slots; at the end of each slot the
// digit index advances and the anode/segment registers are loaded for the new
// digit. Inputs are sampled only when the index wraps 3->0, so a scan never
// mixes two values. An all-0xF snapshot blinks "----" via a two-state FSM.
//
// state   | meaning
// VISIBLE | digits are driven normally (dashes while in overflow)
// DARK    | overflow off-phase, all anodes released
module seven_seg_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_SCANS = 125,
  parameter int LZ_BLANK    = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] BCD0,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD3,
  output logic [3:0] An,
  output logic [6:0] Seg,
  output logic       Dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_SCANS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      snap_q, snap_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  blink_state_e     phase_q, phase_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic       tick;
  logic       wrap;
  logic       lz3, lz2, lz1;
  logic [3:0] code;
  logic       dig_blank;
  logic [6:0] seg_dec;

  // Slot timing: tick marks the last cycle of a digit slot; wrap is the tick
  // that ends digit 3 and starts a new scan.
  always_comb begin
    tick   = (cnt_q == CNT_LAST);
    wrap   = tick && (idx_q == 2'd3);
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = tick ? idx_q + 2'd1 : idx_q;
    snap_d = wrap ? {BCD3, BCD2, BCD1, BCD0} : snap_q;
  end

  // Blink FSM next state. Counting only starts once overflow was already
  // present in the previous scan, so entering overflow gives a full-length
  // visible half-period; leaving overflow restores the display immediately.
  always_comb begin
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt_q;
    if (wrap) begin
      if (snap_d != OVF_WORD) begin
        phase_d     = VISIBLE;
        blink_cnt_d = '0;
      end else if (snap_q == OVF_WORD) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          case (phase_q)
            VISIBLE: phase_d = DARK;
            DARK:    phase_d = VISIBLE;
            default: phase_d = VISIBLE;
          endcase
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end
  end

  // Leading-zero chain on the (possibly just captured) snapshot, then pick the
  // code and blank flag for the digit about to be shown.
  always_comb begin
    lz3 = (LZ_BLANK != 0) && (snap_d[15:12] == 4'd0);
    lz2 = lz3 && (snap_d[11:8] == 4'd0);
    lz1 = lz2 && (snap_d[7:4] == 4'd0);
    code      = snap_d[3:0];
    dig_blank = 1'b0;
    case (idx_d)
      2'd0: begin code = snap_d[3:0];   dig_blank = 1'b0; end
      2'd1: begin code = snap_d[7:4];   dig_blank = lz1;  end
      2'd2: begin code = snap_d[11:8];  dig_blank = lz2;  end
      2'd3: begin code = snap_d[15:12]; dig_blank = lz3;  end
      default: begin code = snap_d[3:0]; dig_blank = 1'b0; end
    endcase
  end

  seg7_decode u_decode (
    .code_i  (code),
    .blank_i (dig_blank),
    .seg_o   (seg_dec)
  );

  // Output register load: only on a tick, using the new index and phase.
  // Blanked digits still pull their anode low to keep brightness constant.
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    if (tick) begin
      if (phase_d == DARK) begin
        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
      end else begin
        an_d  = ~(4'b0001 << idx_d);
        seg_d = seg_dec;
      end
    end
  end

  // Counter, index and snapshot registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q  <= '0;
      idx_q  <= 2'd3;
      snap_q <= 16'h0000;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
    end
  end

  // Blink FSM state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      phase_q     <= VISIBLE;
      blink_cnt_q <= '0;
    end else begin
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  // Display output registers; dark while in reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign An  = an_q;
  assign Seg = seg_q;
  assign Dp  = 1'b1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=4, BLINK_SCANS=2.
// Two instances share the inputs: one with leading-zero blanking, one without.
module tb_seven_seg_scanner;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  logic       Clk;
  logic       Reset;
  logic [3:0] BCD0, BCD1, BCD2, BCD3;
  logic [3:0] An, An_n;
  logic [6:0] Seg, Seg_n;
  logic       Dp, Dp_n;

  int checks;
  int errors;

  seven_seg_scanner #(.REFRESH_DIV(4), .BLINK_SCANS(2), .LZ_BLANK(1)) dut (
    .Clk(Clk), .Reset(Reset),
    .BCD0(BCD0), .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3),
    .An(An), .Seg(Seg), .Dp(Dp)
  );

  seven_seg_scanner #(.REFRESH_DIV(4), .BLINK_SCANS(2), .LZ_BLANK(0)) dut_nolz (
    .Clk(Clk), .Reset(Reset),
    .BCD0(BCD0), .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3),
    .An(An_n), .Seg(Seg_n), .Dp(Dp_n)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0][6:0] seg_lz;   // index = digit
    logic [3:0][6:0] seg_all;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_bcd(input logic [15:0] v);
    BCD3 = v[15:12];
    BCD2 = v[11:8];
    BCD1 = v[7:4];
    BCD0 = v[3:0];
  endtask

  // Advance exactly one digit slot and land on a falling edge.
  task automatic next_slot();
    repeat (4) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk_digit(input string tag, input int d, input logic [6:0] seg_exp);
    logic [3:0] an_exp;
    an_exp = ~(4'b0001 << d);
    chk($sformatf("%s an d%0d", tag, d), {28'd0, An}, {28'd0, an_exp});
    chk($sformatf("%s seg d%0d", tag, d), {25'd0, Seg}, {25'd0, seg_exp});
    chk($sformatf("%s dp d%0d", tag, d), {31'd0, Dp}, 32'd1);
  endtask

  task automatic chk_dark(input string tag);
    chk($sformatf("%s dark an", tag), {28'd0, An}, 32'h0000000f);
    chk($sformatf("%s dark seg", tag), {25'd0, Seg}, {25'd0, SB});
  endtask

  initial begin
    logic [6:0] exp_seq[4];
    logic       vis_pat[6];

    checks = 0;
    errors = 0;

    vecs[0] = '{bcd: 16'h0001, seg_lz: {SB, SB, SB, S1}, seg_all: {S0, S0, S0, S1}};
    vecs[1] = '{bcd: 16'h1024, seg_lz: {S1, S0, S2, S4}, seg_all: {S1, S0, S2, S4}};
    vecs[2] = '{bcd: 16'h0000, seg_lz: {SB, SB, SB, S0}, seg_all: {S0, S0, S0, S0}};
    vecs[3] = '{bcd: 16'h1234, seg_lz: {S1, S2, S3, S4}, seg_all: {S1, S2, S3, S4}};
    vecs[4] = '{bcd: 16'h00A7, seg_lz: {SB, SB, SB, S7}, seg_all: {S0, S0, SB, S7}};
    vecs[5] = '{bcd: 16'h0F00, seg_lz: {SB, SD, S0, S0}, seg_all: {S0, SD, S0, S0}};
    vecs[6] = '{bcd: 16'h9865, seg_lz: {S9, S8, S6, S5}, seg_all: {S9, S8, S6, S5}};

    Reset = 1'b1;
    set_bcd(16'h0000);
    repeat (3) @(negedge Clk);
    chk("reset an", {28'd0, An}, 32'h0000000f);
    chk("reset seg", {25'd0, Seg}, {25'd0, SB});
    chk("reset dp", {31'd0, Dp}, 32'd1);
    chk("reset an nolz", {28'd0, An_n}, 32'h0000000f);
    Reset = 1'b0;

    // One full scan per vector; inputs change while digit 3 is showing.
    for (int v = 0; v < 7; v++) begin
      set_bcd(vecs[v].bcd);
      for (int d = 0; d < 4; d++) begin
        next_slot();
        chk_digit($sformatf("vec%0d", v), d, vecs[v].seg_lz[d]);
        chk($sformatf("vec%0d nolz seg d%0d", v, d), {25'd0, Seg_n}, {25'd0, vecs[v].seg_all[d]});
        chk($sformatf("vec%0d nolz an d%0d", v, d), {28'd0, An_n}, {28'd0, ~(4'b0001 << d)});
      end
    end

    // Input change mid-scan stays invisible until the next wrap.
    set_bcd(16'h1234);
    next_slot(); chk_digit("tear", 0, S4);
    next_slot(); chk_digit("tear", 1, S3);
    set_bcd(16'h5678);
    next_slot(); chk_digit("tear", 2, S2);
    next_slot(); chk_digit("tear", 3, S1);
    exp_seq = '{S8, S7, S6, S5};
    for (int d = 0; d < 4; d++) begin
      next_slot();
      chk_digit("newval", d, exp_seq[d]);
    end

    // Overflow blink: two visible scans, two dark, repeat.
    vis_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    set_bcd(16'hFFFF);
    for (int s = 0; s < 6; s++) begin
      for (int d = 0; d < 4; d++) begin
        next_slot();
        if (vis_pat[s]) chk_digit($sformatf("ovf scan%0d", s), d, SD);
        else            chk_dark($sformatf("ovf scan%0d d%0d", s, d));
      end
    end
    // Seventh scan is dark; drop out of overflow in the middle of it.
    next_slot(); chk_dark("ovf scan6 d0");
    next_slot(); chk_dark("ovf scan6 d1");
    set_bcd(16'h0005);
    next_slot(); chk_dark("ovf scan6 d2");
    next_slot(); chk_dark("ovf scan6 d3");
    next_slot(); chk_digit("exit ovf", 0, S5);
    next_slot(); chk_digit("exit ovf", 1, SB);

    // Asynchronous reset mid-slot, then exact first-digit latency.
    #2;
    Reset = 1'b1;
    #1;
    chk("async rst an", {28'd0, An}, 32'h0000000f);
    chk("async rst seg", {25'd0, Seg}, {25'd0, SB});
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (k < 4) begin
        chk($sformatf("post rst an c%0d", k), {28'd0, An}, 32'h0000000f);
      end else begin
        chk("post rst an c4", {28'd0, An}, 32'h0000000e);
        chk("post rst seg c4", {25'd0, Seg}, {25'd0, S5});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
